// File: rtl/matmul_dot_store.sv
// matmul_dot_store: consumer side of the matmul fetch interface.
// Each valid row/column vector pair is reduced to a dot product in a two-stage
// pipeline and written to C memory at (row_no, col_no). done is raised once
// the last cell (all-ones row and column) has been written.
module matmul_dot_store #(
    parameter int MUL_SIZE  = 8,
    parameter int ADDR_BITS = $clog2(MUL_SIZE),
    parameter int OUT_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [ADDR_BITS-1:0]  row_no,
    input  logic [8*MUL_SIZE-1:0] row,
    input  logic [ADDR_BITS-1:0]  col_no,
    input  logic [8*MUL_SIZE-1:0] col,
    output logic                  c_we,
    output logic [ADDR_BITS-1:0]  c_row,
    output logic [ADDR_BITS-1:0]  c_col,
    output logic [OUT_BITS-1:0]   c_data,
    output logic                  done
);

    // Only the low OUT_BITS of the exact 16+ADDR_BITS sum reach the write
    // port. Low bits of a sum depend only on the low bits of its terms, so
    // products and the adder tree are carried modulo 2^OUT_BITS (capped at
    // their exact widths); the written value equals the exact sum mod 2^OUT_BITS.
    localparam int SUM_BITS  = 16 + ADDR_BITS;
    localparam int PROD_BITS = (OUT_BITS < 16) ? OUT_BITS : 16;
    localparam int ACC_BITS  = (OUT_BITS < SUM_BITS) ? OUT_BITS : SUM_BITS;

    logic [PROD_BITS-1:0] prod [MUL_SIZE];
    logic [ADDR_BITS-1:0] row_no_s1;
    logic [ADDR_BITS-1:0] col_no_s1;
    logic                 v1;
    logic [ACC_BITS-1:0]  sum;
    logic                 last_cell_write;

    // Stage-1 valid bit: the only stage-1 state that must be cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
        end else begin
            v1 <= in_valid;
        end
    end

    // Stage-1 datapath: products and indices, loaded only for valid pairs.
    // NOTE: these data registers carry no reset on purpose; v1 gates every use
    // of them, so their power-up contents can never reach the write port.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int i = 0; i < MUL_SIZE; i++) begin
                prod[i] <= PROD_BITS'(16'(row[8*i +: 8]) * 16'(col[8*i +: 8]));
            end
            row_no_s1 <= row_no;
            col_no_s1 <= col_no;
        end
    end

    // Adder tree over the registered products.
    // NOTE: sum is given a default before the loop so every path assigns it
    // and no latch is inferred.
    always_comb begin
        sum = '0;
        for (int i = 0; i < MUL_SIZE; i++) begin
            sum = sum + ACC_BITS'(prod[i]);
        end
    end

    // Stage 2 doubles as the registered write port; address/data hold while idle.
    // NOTE: non-blocking assignments keep every stage sampling the previous
    // cycle's values, which is what makes this a pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_we   <= 1'b0;
            c_row  <= '0;
            c_col  <= '0;
            c_data <= '0;
        end else begin
            c_we <= v1;
            if (v1) begin
                c_row  <= row_no_s1;
                c_col  <= col_no_s1;
                c_data <= OUT_BITS'(sum);
            end
        end
    end

    assign last_cell_write = c_we && (&c_row) && (&c_col);

    // Sticky done: set by the last-cell write, cleared by start (start wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else if (start) begin
            done <= 1'b0;
        end else if (last_cell_write) begin
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matmul_dot_store.sv
// Self-checking bench for matmul_dot_store: directed cases plus a randomized
// run, all compared cycle by cycle against a transaction-level model.
module tb_matmul_dot_store;

    localparam int N  = 8;
    localparam int AB = 3;
    localparam int OB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start;
    logic          in_valid;
    logic [AB-1:0] row_no;
    logic [AB-1:0] col_no;
    logic [8*N-1:0] row;
    logic [8*N-1:0] col;
    logic          c_we;
    logic [AB-1:0] c_row;
    logic [AB-1:0] c_col;
    logic [OB-1:0] c_data;
    logic          done;

    matmul_dot_store #(.MUL_SIZE(N), .ADDR_BITS(AB), .OUT_BITS(OB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .row_no   (row_no),
        .row      (row),
        .col_no   (col_no),
        .col      (col),
        .c_we     (c_we),
        .c_row    (c_row),
        .c_col    (c_col),
        .c_data   (c_data),
        .done     (done)
    );

    always #5 clk = ~clk;

    // One expected write-port transaction.
    typedef struct {
        bit            v;
        logic [AB-1:0] r;
        logic [AB-1:0] c;
        logic [OB-1:0] d;
    } cell_t;

    cell_t         pipe_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          exp_we;
    logic [AB-1:0] exp_row;
    logic [AB-1:0] exp_col;
    logic [OB-1:0] exp_data;
    logic          exp_done;
    int            we_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Dot product from plain integer arithmetic, reduced modulo 2^OB.
    function automatic logic [OB-1:0] ref_dot(input logic [8*N-1:0] a, input logic [8*N-1:0] b);
        int unsigned s = 0;
        for (int i = 0; i < N; i++) begin
            int unsigned x = a[8*i +: 8];
            int unsigned y = b[8*i +: 8];
            s += x * y;
        end
        return OB'(s);
    endfunction

    function automatic logic [8*N-1:0] splat(input logic [7:0] b);
        logic [8*N-1:0] v;
        for (int i = 0; i < N; i++) v[8*i +: 8] = b;
        return v;
    endfunction

    function automatic logic [8*N-1:0] rand_vec();
        logic [8*N-1:0] v;
        for (int i = 0; i < N; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic drive(input bit v, input int r, input int c,
                         input logic [8*N-1:0] a, input logic [8*N-1:0] b);
        in_valid = v;
        row_no   = AB'(r);
        col_no   = AB'(c);
        row      = a;
        col      = b;
    endtask

    // Idle cycle inputs carry random junk that must be ignored.
    task automatic drive_idle();
        drive(1'b0, $urandom_range(0, N-1), $urandom_range(0, N-1), rand_vec(), rand_vec());
    endtask

    task automatic model_reset();
        cell_t z;
        z.v = 1'b0; z.r = '0; z.c = '0; z.d = '0;
        pipe_q.delete();
        pipe_q.push_back(z);
        exp_we = 1'b0; exp_row = '0; exp_col = '0; exp_data = '0; exp_done = 1'b0;
    endtask

    // Advance one clock with the currently driven inputs, then compare every
    // output with the model. A pair driven now is written two cycles later.
    task automatic step();
        cell_t e;
        cell_t o;
        logic  nd;
        e.v = in_valid; e.r = row_no; e.c = col_no; e.d = ref_dot(row, col);
        pipe_q.push_back(e);
        if (start)
            nd = 1'b0;
        else if (exp_we && exp_row == '1 && exp_col == '1)
            nd = 1'b1;
        else
            nd = exp_done;
        @(posedge clk);
        #1;
        o = pipe_q.pop_front();
        exp_we = o.v;
        if (o.v) begin
            exp_row = o.r; exp_col = o.c; exp_data = o.d;
        end
        exp_done = nd;
        if (c_we) we_seen++;
        check("c_we",   32'(c_we),   32'(exp_we));
        check("c_row",  32'(c_row),  32'(exp_row));
        check("c_col",  32'(c_col),  32'(exp_col));
        check("c_data", 32'(c_data), 32'(exp_data));
        check("done",   32'(done),   32'(exp_done));
    endtask

    initial begin
        start = 1'b0;
        drive(1'b0, 0, 0, '0, '0);
        model_reset();
        #1 rst = 1'b1;
        #2;
        check("rst c_we",   32'(c_we),   32'd0);
        check("rst c_row",  32'(c_row),  32'd0);
        check("rst c_col",  32'(c_col),  32'd0);
        check("rst c_data", 32'(c_data), 32'd0);
        check("rst done",   32'(done),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: single cell, one write pulse two cycles later.
        drive(1'b1, 3, 5, splat(8'h01), splat(8'h02));
        step();
        drive_idle();
        step();
        check("T1 we",   32'(c_we),   32'd1);
        check("T1 row",  32'(c_row),  32'd3);
        check("T1 col",  32'(c_col),  32'd5);
        check("T1 data", 32'(c_data), 32'h10);
        step();
        check("T1 single pulse", 32'(c_we), 32'd0);

        // T2: overflow truncation, and a ramp row.
        begin
            logic [8*N-1:0] ramp;
            for (int i = 0; i < N; i++) ramp[8*i +: 8] = 8'(i + 1);
            drive(1'b1, 1, 2, splat(8'hFF), splat(8'hFF));
            step();
            drive(1'b1, 2, 1, ramp, splat(8'h01));
            step();
            check("T2 ff data", 32'(c_data), 32'h08);
            drive_idle();
            step();
            check("T2 ramp data", 32'(c_data), 32'h24);
            step();
        end

        // T3: all 64 cells back to back in row-major order.
        we_seen = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                drive(1'b1, r, c, rand_vec(), rand_vec());
                step();
            end
        end
        drive_idle();
        step();
        check("T3 last row", 32'(c_row), 32'd7);
        check("T3 last col", 32'(c_col), 32'd7);
        check("T3 done before", 32'(done), 32'd0);
        step();
        check("T3 write count", 32'(we_seen), 32'd64);
        check("T3 done after", 32'(done), 32'd1);

        // T6a: start clears done at the next edge.
        start = 1'b1;
        step();
        start = 1'b0;
        check("T6 start clears", 32'(done), 32'd0);
        step();

        // T6b: start coincident with the last-cell write keeps done low.
        drive(1'b1, 7, 7, rand_vec(), rand_vec());
        step();
        drive_idle();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("T6 start wins", 32'(done), 32'd0);
        step();
        step();
        check("T6 done stays 0", 32'(done), 32'd0);

        // T4: gapped valid pattern; the model checks the shifted c_we and holds.
        begin
            bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
            we_seen = 0;
            foreach (pat[i]) begin
                if (pat[i]) drive(1'b1, $urandom_range(0, N-2), $urandom_range(0, N-1), rand_vec(), rand_vec());
                else        drive_idle();
                step();
            end
            drive_idle();
            step();
            step();
            check("T4 write count", 32'(we_seen), 32'd4);
        end

        // Set done again so reset has something to clear.
        drive(1'b1, 7, 7, rand_vec(), rand_vec());
        step();
        drive_idle();
        step();
        step();
        check("T5 pre done", 32'(done), 32'd1);

        // T5: async reset mid-cycle with two cells in flight.
        drive(1'b1, 4, 4, rand_vec(), rand_vec());
        step();
        drive(1'b1, 5, 5, rand_vec(), rand_vec());
        step();
        drive_idle();
        #2 rst = 1'b1;
        #1;
        check("T5 rst c_we", 32'(c_we), 32'd0);
        check("T5 rst done", 32'(done), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        we_seen = 0;
        for (int k = 0; k < 4; k++) step();
        check("T5 no late write", 32'(we_seen), 32'd0);

        // Randomized run: random valids, indices biased toward the last cell,
        // occasional start.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 7) == 0)
                    drive(1'b1, N-1, N-1, rand_vec(), rand_vec());
                else
                    drive(1'b1, $urandom_range(0, N-1), $urandom_range(0, N-1), rand_vec(), rand_vec());
            end else begin
                drive_idle();
            end
            start = ($urandom_range(0, 15) == 0);
            step();
        end
        start = 1'b0;
        drive_idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog: the stimulus is finite, but never let a stuck run hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
